aes_input_packer: RTL

Upstream feeder for the AES-128 core. Accepts 32-bit words over a valid/ready stream, assembles a 128-bit cipher key and a 128-bit plaintext block, and issues them to the core as `plan_text_128`, `cipher_key_128` and a one-cycle `valid_in` pulse. Enforces a minimum spacing between issues that matches the core's iterative latency, so the core never receives a block while busy.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_input_packer_if.sv | 26 ++
 rtl/aes_input_packer_gap_timer.sv | 27 ++
 rtl/aes_input_packer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES feeder definitions: block/word geometry, packer FSM states and
// the word-slot helper used to place stream words MSB-first in a block.
package aes_pkg;

  localparam int AES_BLOCK_W         = 128;
  localparam int AES_WORD_W          = 32;
  localparam int AES_WORDS_PER_BLOCK = 4;

  typedef enum logic [1:0] {
    S_KEY  = 2'd0,
    S_TEXT = 2'd1,
    S_PEND = 2'd2
  } aes_pack_state_t;

  // Word 0 of a group lands in the top 32 bits, word 3 in the bottom 32 bits.
  function automatic int word_lsb(input logic [1:0] idx);
    return (AES_WORDS_PER_BLOCK - 1 - int'(idx)) * AES_WORD_W;
  endfunction

endpackage

// File: rtl/aes_input_packer_if.sv
// Stream-in / block-out bundle between the feeder source (master) and the
// AES input packer (slave).
interface aes_input_packer_if;
  import aes_pkg::*;

  logic [AES_WORD_W-1:0]  in_data;
  logic                   in_valid;
  logic                   in_key;
  logic                   flush;
  logic                   in_ready;
  logic [AES_BLOCK_W-1:0] plan_text_128;
  logic [AES_BLOCK_W-1:0] cipher_key_128;
  logic                   valid_in;
  logic [31:0]            block_count;

  modport master (
    output in_data, in_valid, in_key, flush,
    input  in_ready, plan_text_128, cipher_key_128, valid_in, block_count
  );

  modport slave (
    input  in_data, in_valid, in_key, flush,
    output in_ready, plan_text_128, cipher_key_128, valid_in, block_count
  );

endinterface

// File: rtl/aes_input_packer_gap_timer.sv
// Issue-spacing timer: 8-bit down-counter saturating at 0, reloadable.
module aes_gap_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       expired
);

  logic [7:0] count_q, count_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load)                 count_d = load_value;
    else if (count_q != 8'd0) count_d = count_q - 8'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= 8'd0;
    else       count_q <= count_d;
  end

  assign expired = (count_q == 8'd0);

endmodule

// File: rtl/aes_input_packer.sv
// Packs 32-bit stream words into AES-128 key/plaintext blocks and issues them
// with minimum spacing. Optional macro AES_PACK_KEY_HOLD_EN keeps a held key.
module aes_input_packer
  import aes_pkg::*;
#(
  parameter int ISSUE_GAP = 11
) (
  input logic               clk,
  input logic               reset,
  aes_input_packer_if.slave bus
);

  localparam logic [7:0] GAP_RELOAD = 8'(ISSUE_GAP - 1);

  aes_pack_state_t        state_q, state_d;
  logic [1:0]             word_cnt_q, word_cnt_d;
  logic [AES_BLOCK_W-1:0] key_asm_q, key_asm_d;
  logic [AES_BLOCK_W-1:0] text_asm_q, text_asm_d;
  logic [AES_BLOCK_W-1:0] key_out_q, text_out_q;
  logic [31:0]            block_count_q;
  logic                   valid_q;
  logic                   ready_en_q;
  logic                   accept;
  logic                   issue;
  logic                   expired;

`ifdef AES_PACK_KEY_HOLD_EN
  logic [1:0] key_cnt_q, key_cnt_d;
  logic       key_loaded_q, key_loaded_d;

  assign bus.in_ready = ready_en_q && (state_q != S_PEND) && !bus.flush &&
                        (bus.in_key || key_loaded_q);
`else
  logic unused_in_key;
  assign unused_in_key = bus.in_key;

  assign bus.in_ready = ready_en_q && (state_q != S_PEND) && !bus.flush;
`endif

  assign accept = bus.in_valid && bus.in_ready;
  assign issue  = (state_q == S_PEND) && expired && !bus.flush;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    key_asm_d  = key_asm_q;
    text_asm_d = text_asm_q;
`ifdef AES_PACK_KEY_HOLD_EN
    key_cnt_d    = key_cnt_q;
    key_loaded_d = key_loaded_q;
    if (accept && bus.in_key) begin
      key_asm_d[word_lsb(key_cnt_q) +: AES_WORD_W] = bus.in_data;
      key_cnt_d = key_cnt_q + 2'd1;
      if (key_cnt_q == 2'd3) key_loaded_d = 1'b1;
    end else if (accept) begin
      text_asm_d[word_lsb(word_cnt_q) +: AES_WORD_W] = bus.in_data;
      word_cnt_d = word_cnt_q + 2'd1;
      state_d    = (word_cnt_q == 2'd3) ? S_PEND : S_TEXT;
    end
    if (issue) state_d = S_KEY;
    // Flush keeps the held key and key_loaded; only partial counters go.
    if (bus.flush) begin
      state_d    = S_KEY;
      word_cnt_d = 2'd0;
      key_cnt_d  = 2'd0;
    end
`else
    case (state_q)
      S_KEY: if (accept) begin
        key_asm_d[word_lsb(word_cnt_q) +: AES_WORD_W] = bus.in_data;
        word_cnt_d = word_cnt_q + 2'd1;
        if (word_cnt_q == 2'd3) state_d = S_TEXT;
      end
      S_TEXT: if (accept) begin
        text_asm_d[word_lsb(word_cnt_q) +: AES_WORD_W] = bus.in_data;
        word_cnt_d = word_cnt_q + 2'd1;
        if (word_cnt_q == 2'd3) state_d = S_PEND;
      end
      S_PEND:  if (issue) state_d = S_KEY;
      default: state_d = S_KEY;
    endcase
    if (bus.flush) begin
      state_d    = S_KEY;
      word_cnt_d = 2'd0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_KEY;
      word_cnt_q    <= 2'd0;
      key_asm_q     <= '0;
      text_asm_q    <= '0;
      key_out_q     <= '0;
      text_out_q    <= '0;
      block_count_q <= 32'd0;
      valid_q       <= 1'b0;
      ready_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      key_asm_q  <= key_asm_d;
      text_asm_q <= text_asm_d;
      valid_q    <= issue;
      ready_en_q <= 1'b1;
      // Outputs only move on issue, so assembly of the next frame never disturbs them.
      if (issue) begin
        key_out_q     <= key_asm_q;
        text_out_q    <= text_asm_q;
        block_count_q <= block_count_q + 32'd1;
      end
    end
  end

`ifdef AES_PACK_KEY_HOLD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_cnt_q    <= 2'd0;
      key_loaded_q <= 1'b0;
    end else begin
      key_cnt_q    <= key_cnt_d;
      key_loaded_q <= key_loaded_d;
    end
  end
`endif

  aes_gap_timer u_gap_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (issue),
    .load_value (GAP_RELOAD),
    .expired    (expired)
  );

  assign bus.plan_text_128  = text_out_q;
  assign bus.cipher_key_128 = key_out_q;
  assign bus.valid_in       = valid_q;
  assign bus.block_count    = block_count_q;

endmodule
